// File: rtl/wallace_final_cpa_seq.sv
// Final carry-propagate adder for the 5x5 Wallace tree: CHUNK bits per clock through one narrow adder; FINAL_CPA_OVF_EN adds the ovf port.
// Latency: out_valid rises WIDTH/CHUNK clocks after the accept edge.
// Backpressure: in_ready is low from accept until the product is taken; product is held while out_ready is low.
module wallace_final_cpa_seq #(
   parameter int WIDTH = 10,
   parameter int CHUNK = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] r1,
   input  logic [WIDTH-1:0] r2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] product,
`ifdef FINAL_CPA_OVF_EN
   output logic             ovf,
`endif
   output logic             busy
);

   localparam int N  = WIDTH / CHUNK;
   localparam int IW = $clog2(N + 1);

   generate
      if (WIDTH % CHUNK != 0) begin : g_bad_chunk
         $error("wallace_final_cpa_seq: WIDTH must be a multiple of CHUNK");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] sum_q;
   logic [IW-1:0]    idx;
   logic             carry_q;

   logic [CHUNK-1:0] a_c;
   logic [CHUNK-1:0] b_c;
   logic [CHUNK:0]   chunk_sum;

   // Chunk select by comparison against constant offsets keeps every slice static.
   always_comb begin
      a_c = '0;
      b_c = '0;
      for (int k = 0; k < N; k++) begin
         if (idx == IW'(k)) begin
            a_c = a_q[k*CHUNK +: CHUNK];
            b_c = b_q[k*CHUNK +: CHUNK];
         end
      end
      chunk_sum = {1'b0, a_c} + {1'b0, b_c} + {{CHUNK{1'b0}}, carry_q};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         a_q       <= '0;
         b_q       <= '0;
         sum_q     <= '0;
         idx       <= '0;
         carry_q   <= 1'b0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_q      <= r1;
                  b_q      <= r2;
                  sum_q    <= '0;
                  idx      <= '0;
                  carry_q  <= 1'b0;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  state    <= ADD;
               end
            end
            ADD: begin
               for (int k = 0; k < N; k++) begin
                  if (idx == IW'(k)) sum_q[k*CHUNK +: CHUNK] <= chunk_sum[CHUNK-1:0];
               end
               carry_q <= chunk_sum[CHUNK];
               idx     <= idx + IW'(1);
               if (idx == IW'(N - 1)) begin
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               busy      <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

   assign product = sum_q;
`ifdef FINAL_CPA_OVF_EN
   assign ovf = carry_q;
`endif

endmodule

// File: tb/tb_wallace_final_cpa_seq.sv
// Bench for wallace_final_cpa_seq: directed cases, backpressure, mid-ADD reset, random 5x5 rows, CHUNK sweep.
module tb_wallace_final_cpa_seq;
   localparam int W = 10;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b0;
   logic [W-1:0] r1 = '0;
   logic [W-1:0] r2 = '0;
   logic         in_ready, out_valid, busy;
   logic [W-1:0] product;

   logic         sw_valid = 1'b0;
   logic [W-1:0] sw_r1 = '0;
   logic [W-1:0] sw_r2 = '0;
   logic         s1_ready, s1_valid, s1_busy, s10_ready, s10_valid, s10_busy;
   logic [W-1:0] s1_prod, s10_prod;
`ifdef FINAL_CPA_OVF_EN
   logic         ovf, s1_ovf, s10_ovf;
`endif

   int           checks = 0;
   int           fails = 0;
   logic [W-1:0] sb[$];
`ifdef FINAL_CPA_OVF_EN
   logic         sb_ovf[$];
`endif

   always #5 clk = ~clk;

   wallace_final_cpa_seq #(.WIDTH(W), .CHUNK(2)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .r1(r1), .r2(r2),
      .out_valid(out_valid), .out_ready(out_ready), .product(product),
`ifdef FINAL_CPA_OVF_EN
      .ovf(ovf),
`endif
      .busy(busy));

   wallace_final_cpa_seq #(.WIDTH(W), .CHUNK(1)) u_c1 (
      .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(s1_ready), .r1(sw_r1), .r2(sw_r2),
      .out_valid(s1_valid), .out_ready(1'b1), .product(s1_prod),
`ifdef FINAL_CPA_OVF_EN
      .ovf(s1_ovf),
`endif
      .busy(s1_busy));

   wallace_final_cpa_seq #(.WIDTH(W), .CHUNK(10)) u_c10 (
      .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(s10_ready), .r1(sw_r1), .r2(sw_r2),
      .out_valid(s10_valid), .out_ready(1'b1), .product(s10_prod),
`ifdef FINAL_CPA_OVF_EN
      .ovf(s10_ovf),
`endif
      .busy(s10_busy));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Accepts one operation, pushes its expected sum, and waits for out_valid.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
      int           lat;
      logic [W:0]   full;
      full = {1'b0, a} + {1'b0, b};
      check({tag, " in_ready before accept"}, 32'(in_ready), 32'd1);
      r1 = a;
      r2 = b;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      sb.push_back(full[W-1:0]);
`ifdef FINAL_CPA_OVF_EN
      sb_ovf.push_back(full[W]);
`endif
      check({tag, " busy after accept"}, 32'(busy), 32'd1);
      lat = 0;
      while (!out_valid && lat < 40) begin
         step();
         lat++;
      end
      check({tag, " latency"}, 32'(lat), 32'd5);
   endtask

   // Completes the output handshake and compares against the scoreboard head.
   task automatic finish_op(input string tag);
      logic [W-1:0] e;
      if (sb.size() == 0) begin
         check({tag, " scoreboard empty"}, 32'(sb.size()), 32'd1);
         return;
      end
      e = sb.pop_front();
      check({tag, " product"}, 32'(product), 32'(e));
`ifdef FINAL_CPA_OVF_EN
      check({tag, " ovf"}, 32'(ovf), 32'(sb_ovf.pop_front()));
`endif
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check({tag, " out_valid after handoff"}, 32'(out_valid), 32'd0);
      check({tag, " product held after handoff"}, 32'(product), 32'(e));
   endtask

   initial begin
      int           done_ops;
      int           cyc;
      int           pa, pb, p, part;
      int           l1, l10;
      logic [W-1:0] e;
      logic         acc, hs;

      // Reset state
      rst = 1'b1;
      step();
      step();
      check("reset in_ready", 32'(in_ready), 32'd1);
      check("reset out_valid", 32'(out_valid), 32'd0);
      check("reset busy", 32'(busy), 32'd0);
      check("reset product", 32'(product), 32'd0);
`ifdef FINAL_CPA_OVF_EN
      check("reset ovf", 32'(ovf), 32'd0);
`endif
      rst = 1'b0;
      step();

      // Directed cases
      run_op(10'h155, 10'h0AB, "basic");
      check("basic constant", 32'(product), 32'h200);
      finish_op("basic");
      run_op(10'h3C1, 10'h000, "max");
      check("max constant", 32'(product), 32'h3C1);
      finish_op("max");
      run_op(10'h3FF, 10'h001, "wrap");
      check("wrap constant", 32'(product), 32'h000);
      finish_op("wrap");

      // Backpressure: DONE held for 4 clocks with a competing input
      run_op(10'h12A, 10'h0F3, "bp");
      for (int i = 0; i < 4; i++) begin
         out_ready = 1'b0;
         in_valid = 1'b1;
         r1 = 10'h003;
         r2 = 10'h004;
         step();
         check("bp out_valid held", 32'(out_valid), 32'd1);
         check("bp product held", 32'(product), 32'h21D);
         check("bp in_ready low", 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0;
      finish_op("bp");
      check("bp ignored input busy", 32'(busy), 32'd0);
      step();
      check("bp ignored input still idle", 32'(busy), 32'd0);

      // Reset at the third ADD clock
      r1 = 10'h2AA;
      r2 = 10'h111;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("midreset in_ready", 32'(in_ready), 32'd1);
      check("midreset out_valid", 32'(out_valid), 32'd0);
      check("midreset product", 32'(product), 32'd0);
      check("midreset busy", 32'(busy), 32'd0);
      run_op(10'h0F0, 10'h00F, "post reset");
      finish_op("post reset");

      // Random 5x5 products split into two rows, back-to-back in_valid
      pa = $urandom_range(0, 31);
      pb = $urandom_range(0, 31);
      p = pa * pb;
      part = $urandom_range(0, p);
      r1 = W'(p - part);
      r2 = W'(part);
      in_valid = 1'b1;
      done_ops = 0;
      cyc = 0;
      while (done_ops < 1000 && cyc < 20000) begin
         out_ready = ($urandom_range(0, 3) != 0);
         acc = in_valid && in_ready;
         hs = out_valid && out_ready;
         if (acc) sb.push_back(W'(p));
         if (hs) begin
            if (sb.size() == 0) check("rand scoreboard empty", 32'(sb.size()), 32'd1);
            else begin
               e = sb.pop_front();
               check("rand product", 32'(product), 32'(e));
            end
`ifdef FINAL_CPA_OVF_EN
            check("rand ovf", 32'(ovf), 32'd0);
`endif
            done_ops++;
         end
         step();
         cyc++;
         if (acc) begin
            pa = $urandom_range(0, 31);
            pb = $urandom_range(0, 31);
            p = pa * pb;
            part = $urandom_range(0, p);
            r1 = W'(p - part);
            r2 = W'(part);
         end
      end
      check("rand ops completed", 32'(done_ops), 32'd1000);
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (out_valid && sb.size() != 0) begin
            e = sb.pop_front();
            check("drain product", 32'(product), 32'(e));
         end
         step();
      end
      out_ready = 1'b0;
      check("scoreboard drained", 32'(sb.size()), 32'd0);

      // CHUNK sweep: latency 10 for CHUNK=1, 1 for CHUNK=10
      check("sweep c1 idle", 32'(s1_ready), 32'd1);
      check("sweep c10 idle", 32'(s10_ready), 32'd1);
      sw_r1 = 10'h1B7;
      sw_r2 = 10'h0C9;
      sw_valid = 1'b1;
      step();
      sw_valid = 1'b0;
      l1 = -1;
      l10 = -1;
      for (int k = 1; k <= 30; k++) begin
         step();
         if (s10_valid && l10 < 0) begin
            l10 = k;
            check("sweep c10 product", 32'(s10_prod), 32'h280);
         end
         if (s1_valid && l1 < 0) begin
            l1 = k;
            check("sweep c1 product", 32'(s1_prod), 32'h280);
         end
      end
      check("sweep c1 latency", 32'(l1), 32'd10);
      check("sweep c10 latency", 32'(l10), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
